// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared memory port,
// with a retired-instruction counter and halt on illegal opcode or memory timeout.
module multicycle_control #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             enable,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             branch,
   output logic             jump,
   output logic             mem_2_reg,
   output logic             reg_write,
   output logic             instr_retired,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic [1:0]       err_code
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6
   } state_e;

   state_e            state_q, state_d;
   logic [6:0]        opcode_q, opcode_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              retire;
   logic              mem_timeout;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= StIdle;
         opcode_q   <= '0;
         wait_cnt_q <= '0;
         instret_q  <= '0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         wait_cnt_q <= wait_cnt_d;
         instret_q  <= instret_d;
         err_code_q <= err_code_d;
      end
   end

   // A ready on the limit cycle still completes the access.
   assign mem_timeout = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      wait_cnt_d    = '0;
      instret_d     = instret_q;
      err_code_d    = err_code_q;
      retire        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      alu_op        = 2'b00;
      alu_src       = 1'b0;
      branch        = 1'b0;
      jump          = 1'b0;
      mem_2_reg     = 1'b0;
      reg_write     = 1'b0;
      instr_retired = 1'b0;
      halted        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StFetch;
         end
         StFetch: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (mem_timeout) begin
               state_d    = StHalt;
               err_code_d = 2'b10;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         StDecode: begin
            opcode_d = opcode;
            case (opcode)
               OP_R, OP_I, OP_BEQ, OP_JAL, OP_LOAD, OP_STORE: state_d = StExec;
               default: begin
                  state_d    = StHalt;
                  err_code_d = 2'b01;
               end
            endcase
         end
         StExec: begin
            case (opcode_q)
               OP_R: begin
                  alu_op  = 2'b10;
                  state_d = StWb;
               end
               OP_I: begin
                  alu_op  = 2'b10;
                  alu_src = 1'b1;
                  state_d = StWb;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src = 1'b1;
                  state_d = StMem;
               end
               OP_BEQ: begin
                  alu_op   = 2'b01;
                  branch   = 1'b1;
                  pc_write = zero;
                  retire   = 1'b1;
               end
               OP_JAL: begin
                  jump     = 1'b1;
                  pc_write = 1'b1;
                  retire   = 1'b1;
               end
               default: begin
                  state_d    = StHalt;
                  err_code_d = 2'b01;
               end
            endcase
         end
         StMem: begin
            i_or_d = 1'b1;
            if (opcode_q == OP_STORE) mem_write = 1'b1;
            else                      mem_read  = 1'b1;
            if (mem_ready) begin
               if (opcode_q == OP_STORE) retire  = 1'b1;
               else                      state_d = StWb;
            end else if (mem_timeout) begin
               state_d    = StHalt;
               err_code_d = 2'b10;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         StWb: begin
            reg_write = 1'b1;
            mem_2_reg = (opcode_q == OP_LOAD);
            retire    = 1'b1;
         end
         StHalt: begin
            halted = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      if (retire) begin
         instr_retired = 1'b1;
         instret_d     = instret_q + CNT_W'(1);
         state_d       = enable ? StFetch : StIdle;
      end
   end

   assign instret  = instret_q;
   assign err_code = err_code_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second instance with a 2-bit counter covers wrap.
module tb_multicycle_control;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BAD   = 7'b1111111;

   // Output vector: mem_read mem_write i_or_d ir_write pc_write alu_op[1:0] alu_src
   //                branch jump mem_2_reg reg_write instr_retired halted err_code[1:0]
   localparam logic [15:0] O_ZERO     = 16'h0000;
   localparam logic [15:0] O_FETCH_W  = 16'h8000;
   localparam logic [15:0] O_FETCH    = 16'h9800;
   localparam logic [15:0] O_EXEC_R   = 16'h0400;
   localparam logic [15:0] O_EXEC_I   = 16'h0500;
   localparam logic [15:0] O_EXEC_LS  = 16'h0100;
   localparam logic [15:0] O_BEQ_T    = 16'h0A88;
   localparam logic [15:0] O_BEQ_N    = 16'h0288;
   localparam logic [15:0] O_JAL      = 16'h0848;
   localparam logic [15:0] O_MEM_LD   = 16'hA000;
   localparam logic [15:0] O_MEM_ST_W = 16'h6000;
   localparam logic [15:0] O_MEM_ST   = 16'h6008;
   localparam logic [15:0] O_WB       = 16'h0018;
   localparam logic [15:0] O_WB_LD    = 16'h0038;
   localparam logic [15:0] O_HALT_ILL = 16'h0005;
   localparam logic [15:0] O_HALT_TO  = 16'h0006;

   logic        clk = 1'b0;
   logic        arst_n, enable, zero, mem_ready;
   logic [6:0]  opcode;
   logic        mem_read, mem_write, i_or_d, ir_write, pc_write, alu_src;
   logic        branch, jump, mem_2_reg, reg_write, instr_retired, halted;
   logic [1:0]  alu_op, err_code;
   logic [31:0] instret;
   logic        w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_pc_write, w_alu_src;
   logic        w_branch, w_jump, w_mem_2_reg, w_reg_write, w_instr_retired, w_halted;
   logic [1:0]  w_alu_op, w_err_code, w_instret;
   logic [15:0] outs;

   int checks   = 0;
   int failures = 0;

   multicycle_control #(.CNT_W(32), .MEM_TIMEOUT(15)) u_dut (
      .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .alu_op(alu_op), .alu_src(alu_src),
      .branch(branch), .jump(jump), .mem_2_reg(mem_2_reg), .reg_write(reg_write),
      .instr_retired(instr_retired), .instret(instret), .halted(halted), .err_code(err_code)
   );

   multicycle_control #(.CNT_W(2), .MEM_TIMEOUT(15)) u_wrap (
      .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_read(w_mem_read), .mem_write(w_mem_write),
      .i_or_d(w_i_or_d), .ir_write(w_ir_write), .pc_write(w_pc_write), .alu_op(w_alu_op),
      .alu_src(w_alu_src), .branch(w_branch), .jump(w_jump), .mem_2_reg(w_mem_2_reg),
      .reg_write(w_reg_write), .instr_retired(w_instr_retired), .instret(w_instret),
      .halted(w_halted), .err_code(w_err_code)
   );

   assign outs = {mem_read, mem_write, i_or_d, ir_write, pc_write, alu_op, alu_src,
                  branch, jump, mem_2_reg, reg_write, instr_retired, halted, err_code};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive this cycle's inputs shortly after the edge, then check the outputs.
   task automatic step(input logic en, input logic [6:0] op, input logic z, input logic rdy,
                       input string tag, input logic [15:0] exp);
      @(posedge clk);
      #2;
      enable    = en;
      opcode    = op;
      zero      = z;
      mem_ready = rdy;
      #1;
      check(tag, {16'h0, outs}, {16'h0, exp});
   endtask

   task automatic release_reset(input logic rdy);
      @(negedge clk);
      arst_n    = 1'b1;
      enable    = 1'b1;
      mem_ready = rdy;
   endtask

   initial begin
      arst_n    = 1'b0;
      enable    = 1'b0;
      opcode    = '0;
      zero      = 1'b0;
      mem_ready = 1'b0;
      #3;
      check("reset_outs", {16'h0, outs}, 32'h0);
      check("reset_instret", instret, 32'd0);
      release_reset(1'b1);

      // R-type then I-type, zero wait states
      step(1, OP_R, 0, 1, "r_fetch", O_FETCH);
      step(1, OP_R, 0, 1, "r_decode", O_ZERO);
      step(1, OP_R, 0, 1, "r_exec", O_EXEC_R);
      step(1, OP_R, 0, 1, "r_wb", O_WB);
      step(1, OP_I, 0, 1, "i_fetch", O_FETCH);
      check("instret_after_r", instret, 32'd1);
      step(1, OP_I, 0, 1, "i_decode", O_ZERO);
      step(1, OP_I, 0, 1, "i_exec", O_EXEC_I);
      step(1, OP_I, 0, 1, "i_wb", O_WB);

      // LOAD with three wait cycles in MEM
      step(1, OP_LOAD, 0, 1, "ld_fetch", O_FETCH);
      check("instret_after_i", instret, 32'd2);
      step(1, OP_LOAD, 0, 1, "ld_decode", O_ZERO);
      step(1, OP_LOAD, 0, 1, "ld_exec", O_EXEC_LS);
      step(1, OP_LOAD, 0, 0, "ld_mem_w1", O_MEM_LD);
      step(1, OP_LOAD, 0, 0, "ld_mem_w2", O_MEM_LD);
      step(1, OP_LOAD, 0, 0, "ld_mem_w3", O_MEM_LD);
      step(1, OP_LOAD, 0, 1, "ld_mem_rdy", O_MEM_LD);
      step(1, OP_LOAD, 0, 1, "ld_wb", O_WB_LD);

      // BEQ taken, BEQ not taken, JAL
      step(1, OP_BEQ, 1, 1, "beq_t_fetch", O_FETCH);
      check("instret_after_ld", instret, 32'd3);
      check("wrap_instret_3", {30'h0, w_instret}, 32'd3);
      step(1, OP_BEQ, 1, 1, "beq_t_decode", O_ZERO);
      step(1, OP_BEQ, 1, 1, "beq_t_exec", O_BEQ_T);
      step(1, OP_BEQ, 0, 1, "beq_n_fetch", O_FETCH);
      check("wrap_instret_0", {30'h0, w_instret}, 32'd0);
      step(1, OP_BEQ, 0, 1, "beq_n_decode", O_ZERO);
      step(1, OP_BEQ, 0, 1, "beq_n_exec", O_BEQ_N);
      step(1, OP_JAL, 0, 1, "jal_fetch", O_FETCH);
      step(1, OP_JAL, 0, 1, "jal_decode", O_ZERO);
      step(1, OP_JAL, 0, 1, "jal_exec", O_JAL);

      // STORE with enable dropped in EXEC; one wait cycle in MEM
      step(1, OP_STORE, 0, 1, "st_fetch", O_FETCH);
      check("instret_after_jal", instret, 32'd6);
      step(1, OP_STORE, 0, 1, "st_decode", O_ZERO);
      step(0, OP_STORE, 0, 1, "st_exec", O_EXEC_LS);
      step(0, OP_STORE, 0, 0, "st_mem_wait", O_MEM_ST_W);
      step(0, OP_STORE, 0, 1, "st_mem_rdy", O_MEM_ST);
      step(0, OP_STORE, 0, 1, "st_idle", O_ZERO);
      step(1, OP_R, 0, 0, "st_idle_en", O_ZERO);
      check("instret_after_st", instret, 32'd7);

      // FETCH: 15 low cycles, ready on the limit cycle -> no timeout
      step(1, OP_R, 0, 0, "reen_fetch", O_FETCH_W);
      for (int i = 1; i < 15; i++) step(1, OP_R, 0, 0, "lim_wait", O_FETCH_W);
      step(1, OP_R, 0, 1, "lim_ready", O_FETCH);
      step(1, OP_R, 0, 1, "lim_decode", O_ZERO);
      step(1, OP_R, 0, 1, "lim_exec", O_EXEC_R);
      step(1, OP_R, 0, 1, "lim_wb", O_WB);

      // Reset in the middle of a LOAD's MEM wait
      step(1, OP_LOAD, 0, 1, "rl_fetch", O_FETCH);
      check("instret_before_rst", instret, 32'd8);
      step(1, OP_LOAD, 0, 1, "rl_decode", O_ZERO);
      step(1, OP_LOAD, 0, 1, "rl_exec", O_EXEC_LS);
      step(1, OP_LOAD, 0, 0, "rl_mem", O_MEM_LD);
      #1 arst_n = 1'b0;
      #1;
      check("rst_mid_outs", {16'h0, outs}, 32'h0);
      check("rst_mid_instret", instret, 32'd0);
      @(posedge clk);
      #3;
      check("rst_hold_outs", {16'h0, outs}, 32'h0);
      release_reset(1'b0);

      // FETCH never ready -> timeout halt
      for (int i = 0; i < 16; i++) step(1, OP_R, 0, 0, "to_wait", O_FETCH_W);
      for (int i = 0; i < 4; i++) step(1, OP_R, 0, 1, "to_halt", O_HALT_TO);
      check("to_instret", instret, 32'd0);

      #1 arst_n = 1'b0;
      release_reset(1'b1);

      // Illegal opcode -> halt, strobes held low
      step(1, OP_BAD, 0, 1, "ill_fetch", O_FETCH);
      step(1, OP_BAD, 0, 1, "ill_decode", O_ZERO);
      for (int i = 0; i < 20; i++) step(1, OP_R, 0, 1'(i), "ill_halt", O_HALT_ILL);
      check("ill_instret", instret, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
